cart_load_ctrl: RTL and testbench
=================================

# cart_load_ctrl

Sequences cartridge image downloads from the HPS ioctl stream into the cartridge memory and shares that single-port memory with the CPU cartridge read path. Holds the machine in reset while the image is written, optionally back-fills the unused part of the cartridge window, and then applies mirroring to CPU reads based on the loaded size. It sits between `hps_io` and the `rx78` cartridge RAM in the emu top level.

## Interface

Parameters:
- `ADDR_W`, 15: cartridge memory address width in bytes (32 KiB).
- `CART_INDEX`, 8'd1: `ioctl_index` value that selects a cartridge download.
- `HOLD_CYCLES`, 16: cycles `cpu_reset` stays asserted after the load completes.

Ports:
- `clk_sys` in 1: system clock. One clock domain only.
- `reset_n` in 1: synchronous, active-low reset.
- `ioctl_download` in 1: download in progress.
- `ioctl_index` in 8: download target index.
- `ioctl_wr` in 1: single-cycle byte strobe.
- `ioctl_addr` in 25: byte address in the image.
- `ioctl_dout` in 8: byte data.
- `cpu_rd` in 1: single-cycle read request.
- `cpu_addr` in ADDR_W: cartridge-relative read address.
- `cpu_dout` out 8: read data.
- `cpu_valid` out 1: `cpu_dout` is valid for this cycle.
- `cpu_reset` out 1: machine reset request.
- `mem_addr` out ADDR_W: memory address.
- `mem_din` out 8: memory write data.
- `mem_we` out 1: memory write strobe.
- `mem_dout` in 8: memory read data, registered, 1-cycle latency.
- `cart_size` out ADDR_W+1: number of bytes loaded.

## Operation

- States: IDLE, LOAD, FILL, HOLD, RUN. Reset enters IDLE.
- IDLE or RUN → LOAD when `ioctl_download` is high and `ioctl_index == CART_INDEX`. On entry, `cart_size` clears to 0. Downloads with any other index are ignored.
- LOAD:
  - Each `ioctl_wr` with `ioctl_addr < 2^ADDR_W` registers the address and data. `mem_we` pulses the next cycle.
  - `cart_size` becomes max(`cart_size`, `ioctl_addr` + 1).
  - Writes at or above 2^ADDR_W are dropped, and `cart_size` does not change.
  - CPU reads are ignored: no `cpu_valid` is produced.
- LOAD exit on the falling edge of `ioctl_download`: go to FILL if `CART_CLEAR_EN` is defined, otherwise go to HOLD.
- FILL: writes 8'hFF to each address from `cart_size` up to 2^ADDR_W−1, one per cycle, then goes to HOLD. If `cart_size` is already 2^ADDR_W, FILL lasts zero cycles.
- HOLD: counts `HOLD_CYCLES`, then goes to RUN.
- `cpu_reset` is 1 in LOAD, FILL and HOLD, and 0 in IDLE and RUN.
- Mirroring in RUN:
  - Mask = (next power of two ≥ `cart_size`) − 1.
  - `mem_addr = cpu_addr & mask`.
  - If `cart_size` is 0, the mask is all ones.
- Reads in IDLE: no mask is applied.
- A new download with the matching index aborts FILL or HOLD immediately and re-enters LOAD.

## Timing

- Reset values:
  - State IDLE.
  - `cpu_reset` 0.
  - `mem_we` 0, `mem_addr` 0, `mem_din` 0.
  - `cpu_valid` 0, `cpu_dout` 0.
  - `cart_size` 0.
- Loader write: `ioctl_wr` at cycle T produces `mem_we` at T+1. Back-to-back strobes on every cycle are sustained.
- CPU read:
  - `cpu_rd` at T drives `mem_addr` at T+1.
  - `cpu_dout` and `cpu_valid` are presented at T+2; `cpu_valid` is high for one cycle.
  - One read per cycle is pipelined.
- `cpu_rd` on the same cycle as the LOAD entry is dropped, and any in-flight read's `cpu_valid` is suppressed.
- An `ioctl_wr` in the same cycle as the `ioctl_download` fall is still written.
- `reset_n` low mid-LOAD returns to IDLE with `cart_size` 0. The memory contents are undefined.

## Configuration

- `CART_CLEAR_EN`:
  - Defined: FILL state is compiled in, so unloaded bytes read 8'hFF.
  - Undefined: FILL is absent, LOAD goes directly to HOLD, and stale memory contents remain.

## Structure

- Shared package `cart_pkg`: state enum `cart_state_t`, and `CART_INDEX` / fill-value constants.
- One sub-module `pow2_mask`: combinational next-power-of-two mask from `cart_size`.

## Test plan

- Load of 8192 bytes with index 1:
  - Memory holds the image.
  - `cart_size` = 8192.
  - `cpu_reset` is high from the download start until FILL + 16 cycles after the download ends.
- After an 8 KiB load, a CPU read at 0x2005 returns the byte at 0x0005, with `cpu_valid` exactly 2 cycles after `cpu_rd`.
- With `CART_CLEAR_EN`, a 100-byte load leaves addresses 100..32767 reading 8'hFF. Without it, the FILL cycle count is 0.
- A download with index 2 causes no `mem_we` and no `cpu_reset`.
- An `ioctl_addr` of 0x8000 is dropped and `cart_size` is unchanged.
- A new index-1 download during HOLD re-enters LOAD and `cpu_reset` stays high. `reset_n` low mid-load sets `cart_size` to 0 and `cpu_reset` to 0 on the next cycle.

Source files
------------

// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge loader: controller states and loader defaults.
package cart_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FILL,
      ST_HOLD,
      ST_RUN
   } cart_state_t;

   localparam logic [7:0] CART_INDEX_DEF = 8'd1;
   localparam logic [7:0] FILL_VAL       = 8'hFF;
endpackage

// File: rtl/cart_load_ctrl_if.sv
// Single-port cartridge memory bus: the controller drives address/data/strobe, memory returns registered read data.
interface cart_load_ctrl_if #(
   parameter int ADDR_W = 15
);
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_din;
   logic              mem_we;
   logic [7:0]        mem_dout;

   modport master (output mem_addr, output mem_din, output mem_we, input mem_dout);
   modport slave  (input mem_addr, input mem_din, input mem_we, output mem_dout);
endinterface

// File: rtl/pow2_mask.sv
// Mirroring mask: (smallest power of two >= cart_size) - 1, all ones for an empty cartridge. Combinational.
module pow2_mask
   import cart_pkg::*;
#(
   parameter int ADDR_W = 15
) (
   input  logic [ADDR_W:0]   cart_size,
   output logic [ADDR_W-1:0] mask
);
   logic [ADDR_W-1:0] smear;

   // A full window has zero low bits, so size-1 wraps to all ones, which is the right mask.
   always_comb begin
      smear = cart_size[ADDR_W-1:0] - ADDR_W'(1);
      for (int i = 0; i < ADDR_W; i++) begin
         smear = smear | (smear >> 1);
      end
      mask = (cart_size == '0) ? '1 : smear;
   end
endmodule

// File: rtl/cart_load_ctrl.sv
// Cartridge download sequencer sharing one memory between the ioctl loader and CPU reads; loader write 1 cycle, CPU read 2 cycles.
// Optional CART_CLEAR_EN back-fills the unused window with 8'hFF before releasing cpu_reset.
module cart_load_ctrl
   import cart_pkg::*;
#(
   parameter int          ADDR_W      = 15,
   parameter logic [7:0]  CART_INDEX  = CART_INDEX_DEF,
   parameter int          HOLD_CYCLES = 16
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              cpu_rd,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [7:0]        cpu_dout,
   output logic              cpu_valid,
   output logic              cpu_reset,
   cart_load_ctrl_if.master  mem,
   output logic [ADDR_W:0]   cart_size
);
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   cart_state_t       state_q;
   logic              cpu_reset_q;
   logic [HOLD_W-1:0] hold_cnt_q;
`ifdef CART_CLEAR_EN
   logic [ADDR_W-1:0] fill_ptr_q;
`endif

   logic [ADDR_W:0]   cart_size_d, cart_size_q;
   logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
   logic [7:0]        mem_din_d, mem_din_q;
   logic              mem_we_d, mem_we_q;
   logic              rd1_d, rd1_q;
   logic              valid_d, valid_q;

   logic              start, cpu_side, cpu_ok, load_wr;
   logic [ADDR_W:0]   wr_end;
   logic [ADDR_W-1:0] run_mask, rd_addr;

   pow2_mask #(.ADDR_W(ADDR_W)) u_mask (
      .cart_size (cart_size_q),
      .mask      (run_mask)
   );

   assign start    = ioctl_download && (ioctl_index == CART_INDEX) && (state_q != ST_LOAD);
   assign cpu_side = (state_q == ST_IDLE) || (state_q == ST_RUN);
   assign cpu_ok   = cpu_rd && cpu_side && !start;
   assign load_wr  = (state_q == ST_LOAD) && ioctl_wr && (ioctl_addr[24:ADDR_W] == '0);
   assign wr_end   = {1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1);
   assign rd_addr  = (state_q == ST_RUN) ? (cpu_addr & run_mask) : cpu_addr;

   always_comb begin
      cart_size_d = cart_size_q;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      mem_we_d    = 1'b0;
      rd1_d       = cpu_ok;
      valid_d     = rd1_q && cpu_side && !start;

      if (start) begin
         cart_size_d = '0;
      end else if (load_wr && (wr_end > cart_size_q)) begin
         cart_size_d = wr_end;
      end

      if (load_wr) begin
         mem_we_d   = 1'b1;
         mem_addr_d = ioctl_addr[ADDR_W-1:0];
         mem_din_d  = ioctl_dout;
`ifdef CART_CLEAR_EN
      end else if ((state_q == ST_FILL) && !start) begin
         mem_we_d   = 1'b1;
         mem_addr_d = fill_ptr_q;
         mem_din_d  = FILL_VAL;
`endif
      end else if (cpu_ok) begin
         mem_addr_d = rd_addr;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         cart_size_q <= '0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         mem_we_q    <= 1'b0;
         rd1_q       <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         cart_size_q <= cart_size_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         mem_we_q    <= mem_we_d;
         rd1_q       <= rd1_d;
         valid_q     <= valid_d;
      end
   end

   // LOAD exits on the download fall; a strobe in that same cycle is already folded into cart_size_d.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cpu_reset_q <= 1'b0;
         hold_cnt_q  <= '0;
`ifdef CART_CLEAR_EN
         fill_ptr_q  <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE, ST_RUN: begin
               if (start) begin
                  state_q     <= ST_LOAD;
                  cpu_reset_q <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (!ioctl_download) begin
`ifdef CART_CLEAR_EN
                  if (cart_size_d[ADDR_W]) begin
                     state_q    <= ST_HOLD;
                     hold_cnt_q <= '0;
                  end else begin
                     state_q    <= ST_FILL;
                     fill_ptr_q <= cart_size_d[ADDR_W-1:0];
                  end
`else
                  state_q    <= ST_HOLD;
                  hold_cnt_q <= '0;
`endif
               end
            end
`ifdef CART_CLEAR_EN
            ST_FILL: begin
               if (start) begin
                  state_q <= ST_LOAD;
               end else if (fill_ptr_q == '1) begin
                  state_q    <= ST_HOLD;
                  hold_cnt_q <= '0;
               end else begin
                  fill_ptr_q <= fill_ptr_q + ADDR_W'(1);
               end
            end
`endif
            ST_HOLD: begin
               if (start) begin
                  state_q <= ST_LOAD;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  state_q     <= ST_RUN;
                  cpu_reset_q <= 1'b0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               cpu_reset_q <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_reset    = cpu_reset_q;
   assign cpu_valid    = valid_q;
   assign cpu_dout     = valid_q ? mem.mem_dout : 8'h00;
   assign cart_size    = cart_size_q;
   assign mem.mem_addr = mem_addr_q;
   assign mem.mem_din  = mem_din_q;
   assign mem.mem_we   = mem_we_q;
endmodule

// File: tb/tb_cart_load_ctrl.sv
// Bench for cart_load_ctrl: attached 32 KiB RAM, reference image array and mirroring model driven by directed/random steps.
module tb_cart_load_ctrl;
   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        cpu_rd;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        cpu_valid;
   logic        cpu_reset;
   logic [15:0] cart_size;

   cart_load_ctrl_if #(.ADDR_W(15)) mbus ();

   cart_load_ctrl #(.ADDR_W(15), .CART_INDEX(8'd1), .HOLD_CYCLES(16)) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .cpu_rd         (cpu_rd),
      .cpu_addr       (cpu_addr),
      .cpu_dout       (cpu_dout),
      .cpu_valid      (cpu_valid),
      .cpu_reset      (cpu_reset),
      .mem            (mbus),
      .cart_size      (cart_size)
   );

   always #5 clk_sys = ~clk_sys;

   logic [7:0] ram [0:32767];
   bit ram_seeded = 1'b0;
   always @(posedge clk_sys) begin
      if (!ram_seeded) begin
         for (int i = 0; i < 32768; i++) ram[i] <= 8'(i * 13 + 7);
         ram_seeded <= 1'b1;
      end else if (mbus.mem_we) begin
         ram[mbus.mem_addr] <= mbus.mem_din;
      end
      mbus.mem_dout <= ram[mbus.mem_addr];
   end

   logic [7:0] ref_mem [0:32767];
   int  model_size = 0;
   bit  model_run  = 1'b0;
   int  wq[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic int ref_mask(input int size);
      int p = 1;
      if (size == 0) return 32'h7FFF;
      while (p < size) p = p * 2;
      return p - 1;
   endfunction

   function automatic int eff_addr(input int a);
      return model_run ? (a & ref_mask(model_size)) : a;
   endfunction

   function automatic int mem_diff();
      int d = 0;
      for (int i = 0; i < 32768; i++) if (ram[i] !== ref_mem[i]) d++;
      return d;
   endfunction

   // Reads issued at cycle T: address seen on the bus at T+1, data and valid at T+2.
   task automatic read_burst(input int n, input bit fixed, input int fa);
      bit         v1 = 1'b0;
      logic [7:0] d1 = 8'h00;
      int bad_a = 0, bad_v = 0, bad_d = 0;
      for (int i = 0; i < n + 2; i++) begin
         bit rd;
         int a;
         if (fixed) begin
            rd = (i == 0);
            a  = fa;
         end else begin
            rd = (i < n) && ($urandom_range(0, 3) != 0);
            a  = $urandom_range(0, 32767);
         end
         cpu_rd   = rd;
         cpu_addr = 15'(a);
         step();
         if (rd && (int'(mbus.mem_addr) != eff_addr(a))) bad_a++;
         if (cpu_valid !== v1) bad_v++;
         if (v1 && (cpu_dout !== d1)) bad_d++;
         v1 = rd;
         d1 = ref_mem[eff_addr(a)];
      end
      cpu_rd = 1'b0;
      chk("rd_addr", bad_a, 0);
      chk("rd_valid", bad_v, 0);
      chk("rd_data", bad_d, 0);
   endtask

   task automatic load_image(input bit fall_at_end, input bit run_to_end);
      int bad_we = 0, bad_sz = 0, bad_rst = 0;
      int a, cnt, exp_cnt;
      logic [7:0] d;
      bit exp_we;
      cpu_rd   = 1'b1;
      cpu_addr = 15'($urandom_range(0, 32767));
      step();
      ioctl_download = 1'b1;
      ioctl_index    = 8'd1;
      ioctl_wr       = 1'b0;
      step();
      cpu_rd = 1'b0;
      model_size = 0;
      model_run  = 1'b0;
      chk("rd_inflight_drop", cpu_valid, 0);
      chk("entry_reset_hi", cpu_reset, 1);
      chk("entry_size_clear", cart_size, 0);
      step();
      chk("rd_entry_drop", cpu_valid, 0);
      for (int k = 0; k < wq.size(); k++) begin
         if ($urandom_range(0, 3) == 0) begin
            ioctl_wr = 1'b0;
            step();
            if (mbus.mem_we !== 1'b0) bad_we++;
            if (cpu_reset !== 1'b1) bad_rst++;
         end
         a = wq[k];
         d = 8'($urandom);
         ioctl_wr   = 1'b1;
         ioctl_addr = 25'(a);
         ioctl_dout = d;
         if (fall_at_end && (k == wq.size() - 1)) ioctl_download = 1'b0;
         step();
         ioctl_wr = 1'b0;
         exp_we = (a < 32768);
         if (exp_we) begin
            ref_mem[a] = d;
            if (a + 1 > model_size) model_size = a + 1;
         end
         if ((mbus.mem_we !== exp_we) ||
             (exp_we && ((int'(mbus.mem_addr) != a) || (mbus.mem_din !== d)))) bad_we++;
         if (int'(cart_size) != model_size) bad_sz++;
         if (cpu_reset !== 1'b1) bad_rst++;
      end
      chk("load_mem_we", bad_we, 0);
      chk("load_cart_size", bad_sz, 0);
      chk("load_reset_hi", bad_rst, 0);
      if (fall_at_end && run_to_end) begin
`ifdef CART_CLEAR_EN
         exp_cnt = 16 + 32768 - model_size;
         for (int i = model_size; i < 32768; i++) ref_mem[i] = 8'hFF;
`else
         exp_cnt = 16;
`endif
         cnt = 0;
         while ((cpu_reset === 1'b1) && (cnt < 40000)) begin
            cnt++;
            step();
         end
         chk("reset_tail_cycles", cnt, exp_cnt);
         model_run = 1'b1;
         chk("mem_image", mem_diff(), 0);
      end
   endtask

   initial begin
      int we_seen, rst_seen, bad;
      reset_n = 1'b0;
      ioctl_download = 1'b0;
      ioctl_index = 8'd0;
      ioctl_wr = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = 8'd0;
      cpu_rd = 1'b0;
      cpu_addr = '0;
      for (int i = 0; i < 32768; i++) ref_mem[i] = 8'(i * 13 + 7);

      repeat (3) step();
      chk("rst_cpu_reset", cpu_reset, 0);
      chk("rst_mem_we", mbus.mem_we, 0);
      chk("rst_mem_addr", mbus.mem_addr, 0);
      chk("rst_mem_din", mbus.mem_din, 0);
      chk("rst_cpu_valid", cpu_valid, 0);
      chk("rst_cpu_dout", cpu_dout, 0);
      chk("rst_cart_size", cart_size, 0);
      reset_n = 1'b1;
      step();

      read_burst(20, 1'b0, 0);

      // Foreign index: no writes and the machine keeps running.
      we_seen = 0;
      rst_seen = 0;
      ioctl_download = 1'b1;
      ioctl_index = 8'd2;
      for (int i = 0; i < 30; i++) begin
         ioctl_wr   = 1'($urandom_range(0, 1));
         ioctl_addr = 25'($urandom_range(0, 32767));
         ioctl_dout = 8'($urandom);
         step();
         if (mbus.mem_we !== 1'b0) we_seen++;
         if (cpu_reset !== 1'b0) rst_seen++;
      end
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      step();
      if (mbus.mem_we !== 1'b0) we_seen++;
      chk("idx2_mem_we", we_seen, 0);
      chk("idx2_cpu_reset", rst_seen, 0);
      chk("idx2_cart_size", cart_size, 0);

      // 8 KiB image with an out-of-window byte in the middle.
      wq.delete();
      for (int i = 0; i < 8192; i++) begin
         if (i == 4000) wq.push_back(32'h8000);
         wq.push_back(i);
      end
      load_image(1'b1, 1'b1);
      chk("load8k_cart_size", cart_size, 8192);
      chk("run_cpu_reset", cpu_reset, 0);
      read_burst(1, 1'b1, 32'h2005);
      read_burst(150, 1'b0, 0);

      // 100-byte image written top-down.
      wq.delete();
      for (int i = 99; i >= 0; i--) wq.push_back(i);
      load_image(1'b1, 1'b1);
      chk("load100_cart_size", cart_size, 100);
      read_burst(100, 1'b0, 0);

      // Full-window image, then a second download aborting HOLD, then reset mid-load.
      wq.delete();
      wq.push_back(32'h10);
      wq.push_back(32'h7FFF);
      wq.push_back(32'h8000);
      wq.push_back(32'h20);
      load_image(1'b1, 1'b0);
      chk("full_cart_size", cart_size, 32768);
      bad = 0;
      repeat (5) begin
         step();
         if (cpu_reset !== 1'b1) bad++;
      end
      chk("hold_reset_hi", bad, 0);
      wq.delete();
      wq.push_back(32'h30);
      wq.push_back(32'h31);
      wq.push_back(32'h8000);
      wq.push_back(32'h32);
      load_image(1'b0, 1'b0);
      ioctl_wr = 1'b0;
      step();
      reset_n = 1'b0;
      ioctl_download = 1'b0;
      step();
      chk("midload_rst_size", cart_size, 0);
      chk("midload_rst_cpu_reset", cpu_reset, 0);
      chk("midload_rst_valid", cpu_valid, 0);
      reset_n = 1'b1;
      model_size = 0;
      model_run = 1'b0;
      step();
      read_burst(40, 1'b0, 0);
      chk("final_mem_image", mem_diff(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
